// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: fixed-point Mandelbrot iteration engine.
// Takes one point c per in_valid/in_ready handshake, iterates z <= z^2 + c
// once per clock, and returns escape count, inside flag and an RGB colour
// over an out_valid/out_ready handshake. flush aborts the point in flight.
// Optional build macro MANDEL_PERIOD_CHECK_EN adds an early interior exit
// when the orbit returns exactly to a saved point.
module mandel_iter_engine #(
  parameter  int WIDTH    = 16,
  parameter  int FRAC     = 12,
  parameter  int MAX_ITER = 255,
  localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] cr_in,
  input  logic signed [WIDTH-1:0] ci_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    is_mandelbrot,
  output logic [ITER_W-1:0]       iter_count,
  output logic [23:0]             color,
  output logic                    busy
);

  localparam int DW = 2 * WIDTH;      // product width
  localparam int PW = 2 * WIDTH + 1;  // sum/difference width, never overflows
  localparam logic signed [PW-1:0] ESC_LIMIT = PW'(1) << (2 * FRAC + 2);
  localparam logic [ITER_W-1:0]    LIMIT     = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] cr, ci, zr, zi;
  logic [ITER_W-1:0]       n;

  logic signed [DW-1:0]    zr_sq, zi_sq, zr_zi;
  logic signed [PW-1:0]    mag2, re_full, im_full;
  logic signed [WIDTH-1:0] zr_next, zi_next;
  logic [ITER_W-1:0]       n_next;
  logic                    escape, at_limit;
  logic [7:0]              n8;
  logic [23:0]             esc_color;

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [WIDTH-1:0] zs_r, zs_i;
  logic                    repeat_hit, n_next_pow2;
`endif

  // Datapath for one iteration: magnitude test and next z, wrapping to WIDTH.
  // NOTE: every signal written here gets a value on every path, otherwise
  // the tool infers a latch to hold the old value.
  always_comb begin
    zr_sq     = DW'(zr) * DW'(zr);
    zi_sq     = DW'(zi) * DW'(zi);
    zr_zi     = DW'(zr) * DW'(zi);
    mag2      = PW'(zr_sq) + PW'(zi_sq);
    re_full   = PW'(zr_sq) - PW'(zi_sq);
    im_full   = PW'(zr_zi) <<< 1;
    zr_next   = WIDTH'(re_full >>> FRAC) + cr;
    zi_next   = WIDTH'(im_full >>> FRAC) + ci;
    escape    = mag2 > ESC_LIMIT;
    at_limit  = n == LIMIT;
    n_next    = n + ITER_W'(1);
    n8        = 8'(n);
    esc_color = {n8, n8[5:0], 2'b00, n8[3:0], 4'b0000};
`ifdef MANDEL_PERIOD_CHECK_EN
    repeat_hit  = (zr_next == zs_r) && (zi_next == zs_i);
    n_next_pow2 = (n_next & (n_next - ITER_W'(1))) == '0;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      is_mandelbrot <= 1'b0;
      iter_count    <= '0;
      color         <= '0;
      busy          <= 1'b0;
      cr            <= '0;
      ci            <= '0;
      zr            <= '0;
      zi            <= '0;
      n             <= '0;
`ifdef MANDEL_PERIOD_CHECK_EN
      zs_r          <= '0;
      zs_i          <= '0;
`endif
    end else if (flush) begin
      // Abort wins over any handshake on the same edge.
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      is_mandelbrot <= 1'b0;
      iter_count    <= '0;
      color         <= '0;
      busy          <= 1'b0;
      zr            <= '0;
      zi            <= '0;
      n             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cr       <= cr_in;
            ci       <= ci_in;
            zr       <= '0;
            zi       <= '0;
            n        <= '0;
`ifdef MANDEL_PERIOD_CHECK_EN
            zs_r     <= '0;
            zs_i     <= '0;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ITER;
          end
        end
        ITER: begin
          if (escape) begin
            is_mandelbrot <= 1'b0;
            iter_count    <= n;
            color         <= esc_color;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else if (at_limit) begin
            is_mandelbrot <= 1'b1;
            iter_count    <= LIMIT;
            color         <= '0;
            out_valid     <= 1'b1;
            state         <= DONE;
`ifdef MANDEL_PERIOD_CHECK_EN
          end else if (repeat_hit) begin
            // Orbit came back to a saved point: periodic, hence interior.
            is_mandelbrot <= 1'b1;
            iter_count    <= LIMIT;
            color         <= '0;
            out_valid     <= 1'b1;
            state         <= DONE;
`endif
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            n  <= n_next;
`ifdef MANDEL_PERIOD_CHECK_EN
            // Brent-style checkpoints at n+1 = 1, 2, 4, 8, ...
            if (n_next_pow2) begin
              zs_r <= zr_next;
              zs_i <= zi_next;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
